// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte buffer, framing/overrun flags
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  receiver enable (0 aborts any frame, buffer/flags kept)
//   baud_div            bit period minus one, in clocks
//   rx                  asynchronous serial line, idle high
//   rd_ack              one-cycle pulse: buffer consumed
//   rx_data, rx_valid   buffered byte and its valid flag
//   busy                frame reception in progress
//   frame_err, overrun  sticky error flags of the buffered byte
//   parity_err          sticky even-parity error (UART_RX_PARITY_EN, else 0)
// Build option: define UART_RX_PARITY_EN for an even parity bit between data and stop.
module uart_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int DIV_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             rx,
   input  logic             rd_ack,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun,
   output logic             parity_err
);
`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic par_bit;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   assign parity_err = 1'b0;
`endif
   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [DIV_W-1:0]       cnt, limit;
   logic [2:0]             idx;
   logic [7:0]             shift;
   logic                   rxs, fall, hit, stop_hit;
   assign rxs      = sync_q[SYNC_STAGES-1];
   // falling edge of rxs taken on the edge where it becomes 0
   assign fall     = rxs & ~sync_q[SYNC_STAGES-2];
   assign limit    = (state == START) ? baud_div >> 1 : baud_div;
   assign hit      = cnt == limit;
   assign stop_hit = en && state == STOP && hit;
   assign busy     = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sync_q    <= '1;
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
         if (!en) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE:
                  if (fall) begin
                     state <= START;
                     cnt   <= '0;
                  end
               START:
                  if (hit) begin
                     state <= rxs ? IDLE : DATA;
                     cnt   <= '0;
                     idx   <= '0;
                  end else cnt <= cnt + 1'b1;
               DATA:
                  if (hit) begin
                     shift[idx] <= rxs;
                     idx        <= idx + 3'd1;
                     cnt        <= '0;
`ifdef UART_RX_PARITY_EN
                     if (idx == 3'd7) state <= PARITY;
`else
                     if (idx == 3'd7) state <= STOP;
`endif
                  end else cnt <= cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
               PARITY:
                  if (hit) begin
                     par_bit <= rxs;
                     state   <= STOP;
                     cnt     <= '0;
                  end else cnt <= cnt + 1'b1;
`endif
               STOP:
                  if (hit) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else cnt <= cnt + 1'b1;
               default: state <= IDLE;
            endcase
         end
         // a read in the stop-sample cycle frees the buffer for the new byte
         if (stop_hit && (!rx_valid || rd_ack)) begin
            rx_data   <= shift;
            rx_valid  <= 1'b1;
            frame_err <= ~rxs;
`ifdef UART_RX_PARITY_EN
            parity_err <= (^shift) ^ par_bit;
`endif
         end else if (stop_hit) begin
            overrun <= 1'b1;
         end else if (rd_ack && rx_valid) begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
         end
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at baud_div=15
module tb_uart_rx;
   logic        clk = 1'b0;
   logic        rst_n, en, rx, rd_ack;
   logic [31:0] baud_div;
   logic [7:0]  rx_data;
   logic        rx_valid, busy, frame_err, overrun, parity_err;
   int          tests = 0;
   int          fails = 0;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 169;
   logic par_flip = 1'b0;
`else
   localparam int LAT = 153;
`endif
   uart_rx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .baud_div  (baud_div),
      .rx        (rx),
      .rd_ack    (rd_ack),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .parity_err(parity_err)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic hold();
      repeat (16) @(posedge clk);
      #1;
   endtask
   // rx drops 1 time unit after the first posedge; the next posedge captures it
   task automatic send(input logic [7:0] b, input logic stop_v);
      @(posedge clk);
      #1 rx = 1'b0;
      hold();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         hold();
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ par_flip;
      hold();
`endif
      rx = stop_v;
      hold();
      rx = 1'b1;
   endtask
   task automatic ack();
      @(posedge clk);
      #1 rd_ack = 1'b1;
      @(posedge clk);
      #1 rd_ack = 1'b0;
   endtask
   task automatic check_flags(input string tag, input logic v, input logic fe, input logic ov);
      check({tag, "_valid"}, rx_valid, v);
      check({tag, "_frame"}, frame_err, fe);
      check({tag, "_ovr"}, overrun, ov);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      rst_n = 1'b0; en = 1'b1; baud_div = 32'd15; rx = 1'b1; rd_ack = 1'b0;
      #12;
      check("rst_data", rx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_par", parity_err, 1'b0);
      check_flags("rst", 1'b0, 1'b0, 1'b0);
      #11 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      // 1: 0xA5 with exact latency
      fork
         send(8'hA5, 1'b1);
         begin
            @(posedge clk);
            repeat (LAT) @(posedge clk);
            #1 check("t1_lat_early", rx_valid, 1'b0);
            @(posedge clk);
            #1 check("t1_lat", rx_valid, 1'b1);
            @(posedge clk);
            #1 check("t1_busy", busy, 1'b0);
         end
      join
      check("t1_data", rx_data, 8'hA5);
      check("t1_par", parity_err, 1'b0);
      check_flags("t1", 1'b1, 1'b0, 1'b0);
      ack();
      #1 check("t1_ack", rx_valid, 1'b0);
      // 2: false start
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("t2_busy_on", busy, 1'b1);
      @(posedge clk);
      #1 rx = 1'b1;
      repeat (6) @(posedge clk);
      #1 check("t2_busy_hold", busy, 1'b1);
      @(posedge clk);
      #1 check("t2_busy_off", busy, 1'b0);
      repeat (200) @(posedge clk);
      #1 check("t2_idle", busy, 1'b0);
      check_flags("t2", 1'b0, 1'b0, 1'b0);
      // 3: framing error
      send(8'h3C, 1'b0);
      check("t3_data", rx_data, 8'h3C);
      check_flags("t3", 1'b1, 1'b1, 1'b0);
      ack();
      #1 check_flags("t3_ack", 1'b0, 1'b0, 1'b0);
      // 4: overrun, then read on the stop-sample cycle
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      check("t4_data", rx_data, 8'h11);
      check_flags("t4", 1'b1, 1'b0, 1'b1);
      ack();
      #1 check_flags("t4_ack", 1'b0, 1'b0, 1'b0);
      send(8'h11, 1'b1);
      fork
         send(8'h22, 1'b1);
         begin
            @(posedge clk);
            repeat (LAT) @(posedge clk);
            #1 rd_ack = 1'b1;
            @(posedge clk);
            #1 rd_ack = 1'b0;
         end
      join
      check("t4b_data", rx_data, 8'h22);
      check_flags("t4b", 1'b1, 1'b0, 1'b0);
      // 5: async reset during bit 4 of 0xF0
      fork
         send(8'hF0, 1'b1);
         begin
            @(posedge clk);
            repeat (88) @(posedge clk);
            #1 check("t5_busy_pre", busy, 1'b1);
            #2 rst_n = 1'b0;
            #1 check("t5_data", rx_data, 8'h00);
            check("t5_busy", busy, 1'b0);
            check_flags("t5", 1'b0, 1'b0, 1'b0);
         end
      join
      #3 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      send(8'h5A, 1'b1);
      check("t5_after", rx_data, 8'h5A);
      check_flags("t5_after", 1'b1, 1'b0, 1'b0);
      ack();
      // 6: byte stream with reads in between
      send(8'h00, 1'b1);
      check("t6_00", rx_data, 8'h00);
      check("t6_00_v", rx_valid, 1'b1);
      ack();
      send(8'hFF, 1'b1);
      check("t6_ff", rx_data, 8'hFF);
      check("t6_ff_v", rx_valid, 1'b1);
      ack();
      send(8'h55, 1'b1);
      check("t6_55", rx_data, 8'h55);
      check_flags("t6_55", 1'b1, 1'b0, 1'b0);
      ack();
`ifdef UART_RX_PARITY_EN
      par_flip = 1'b1;
      send(8'h3A, 1'b1);
      par_flip = 1'b0;
      check("t6_perr", parity_err, 1'b1);
      check("t6_perr_d", rx_data, 8'h3A);
      ack();
      #1 check("t6_perr_clr", parity_err, 1'b0);
`endif
      // enable drop mid-frame aborts without flags
      fork
         send(8'h77, 1'b1);
         begin
            @(posedge clk);
            repeat (40) @(posedge clk);
            #1 en = 1'b0;
            @(posedge clk);
            #1 check("en_abort", busy, 1'b0);
         end
      join
      en = 1'b1;
      repeat (5) @(posedge clk);
      #1 check("en_busy", busy, 1'b0);
      check_flags("en", 1'b0, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
